// File: rtl/rv32i_types.sv
// Shared RV32I front-end types used by the fetch stage and its response buffer.
package rv32i_types;

  // Hard ceiling on in-flight imem requests any fetch configuration may use.
  localparam int FETCH_MAX_OUTSTANDING = 4;

  // Record handed from fetch to the instruction queue.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] out_inst;
  } if_id_stage_reg_t;

  // One returned instruction waiting in the response buffer.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_buf_entry_t;

  // One outstanding imem request; kill marks it as belonging to a dead path.
  typedef struct packed {
    logic [31:0] pc;
    logic        kill;
  } fetch_trk_entry_t;

  // Sequential successor; wraps modulo 2^32.
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Parametrised width/depth FIFO with synchronous flush, used as the fetch
// response buffer. DEPTH must be a power of two and at least 2 so the
// pointers wrap naturally. The caller never pushes when full or pops when empty.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  // Storage write; a flush in the same cycle discards the pushed word.
  // NOTE: the data array has no reset -- validity lives entirely in the
  // pointers/count, and resetting storage would only cost area and timing.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointer and occupancy bookkeeping; flush empties the buffer in one cycle.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/fetch_multi_outstanding.sv
// Instruction fetch stage with up to OUTSTANDING in-order imem requests in
// flight. Returned instructions land in a response buffer sized by credits,
// so a stalled instruction queue never loses a memory response. Redirects
// flush the buffer and kill in-flight requests from the old path.
// Optional feature macro: FETCH_PREDICT_EN (adds prediction/predict_pc and
// a predicted-taken redirect on enqueue).
module fetch_multi_outstanding
  import rv32i_types::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h6000_0000,
  parameter int          OUTSTANDING = 2,
  parameter int          BUF_DEPTH   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             full,
  input  logic             branch,
  input  logic [31:0]      br_pc,
`ifdef FETCH_PREDICT_EN
  input  logic             prediction,
  input  logic [31:0]      predict_pc,
`endif
  input  logic             imem_ready,
  input  logic             imem_resp,
  input  logic [31:0]      imem_rdata,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  output logic [3:0]       imem_rmask,
  output logic             enq,
  output if_id_stage_reg_t if_id_reg_next
);

  localparam int TAW  = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int IW   = $clog2(FETCH_MAX_OUTSTANDING + 1);
  localparam int CNTW = $clog2(BUF_DEPTH) + 1;
  localparam int SW   = ((IW > CNTW) ? IW : CNTW) + 1;

  // Fetch PC and in-order request tracker.
  logic [31:0]      r_pc;
  fetch_trk_entry_t r_trk [OUTSTANDING];
  logic [TAW-1:0]   r_trk_wr;
  logic [TAW-1:0]   r_trk_rd;
  logic [IW-1:0]    r_inflight;

  // Response buffer interface.
  fetch_buf_entry_t w_buf_wdata;
  fetch_buf_entry_t w_buf_head;
  logic             w_buf_push;
  logic             w_buf_empty;
  logic [CNTW-1:0]  w_buf_count;

  logic             w_issue;
  logic             w_redirect;
  logic             w_pred_redirect;
  logic [31:0]      w_target;
  logic [SW-1:0]    w_credit_used;
  fetch_trk_entry_t w_trk_head;

  // Tracker depth need not be a power of two, so wrap explicitly.
  function automatic logic [TAW-1:0] trk_inc(input logic [TAW-1:0] ptr);
    return (ptr == TAW'(OUTSTANDING - 1)) ? '0 : ptr + TAW'(1);
  endfunction

`ifdef FETCH_PREDICT_EN
  // A predicted-taken entry still enqueues; everything younger is squashed.
  assign w_pred_redirect = enq && prediction;
  assign w_target        = branch ? br_pc : predict_pc;
`else
  assign w_pred_redirect = 1'b0;
  assign w_target        = br_pc;
`endif

  assign w_redirect    = branch || w_pred_redirect;
  assign w_credit_used = SW'(r_inflight) + SW'(w_buf_count);

  // Credit rule: only issue when the returning response is sure of a slot.
  assign imem_req   = !rst && !branch
                    && (r_inflight < IW'(OUTSTANDING))
                    && (w_credit_used < SW'(BUF_DEPTH));
  assign imem_addr  = r_pc;
  assign imem_rmask = 4'hF;
  assign w_issue    = imem_req && imem_ready;

  // Responses return in order, so the tracker head always names them.
  assign w_trk_head  = r_trk[r_trk_rd];
  assign w_buf_push  = imem_resp && !w_trk_head.kill && !w_redirect;
  assign w_buf_wdata = '{pc: w_trk_head.pc, inst: imem_rdata};

  assign enq = !rst && !w_buf_empty && !full && !branch;

  // Present the buffer head to the queue; zero while empty or in reset.
  // NOTE: defaults first in always_comb so no path can infer a latch.
  always_comb begin
    if_id_reg_next = '0;
    if (!rst && !w_buf_empty) begin
      if_id_reg_next.pc       = w_buf_head.pc;
      if_id_reg_next.pc_next  = pc_inc(w_buf_head.pc);
      if_id_reg_next.out_inst = w_buf_head.inst;
    end
  end

  // Fetch PC: redirect beats sequential advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (w_redirect) begin
      r_pc <= w_target;
    end else if (w_issue) begin
      r_pc <= pc_inc(r_pc);
    end
  end

  // Tracker: push on issue, pop on response, kill every entry on redirect
  // (the entry pushed in the redirect cycle is written already killed).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_trk_wr   <= '0;
      r_trk_rd   <= '0;
      r_inflight <= '0;
      for (int i = 0; i < OUTSTANDING; i++) begin
        r_trk[i] <= '0;
      end
    end else begin
      if (w_redirect) begin
        for (int i = 0; i < OUTSTANDING; i++) begin
          r_trk[i].kill <= 1'b1;
        end
      end
      if (w_issue) begin
        r_trk[r_trk_wr].pc   <= r_pc;
        r_trk[r_trk_wr].kill <= w_redirect;
        r_trk_wr             <= trk_inc(r_trk_wr);
      end
      if (imem_resp) begin
        r_trk_rd <= trk_inc(r_trk_rd);
      end
      case ({w_issue, imem_resp})
        2'b10:   r_inflight <= r_inflight + IW'(1);
        2'b01:   r_inflight <= r_inflight - IW'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  // A response with nothing in flight means memory and fetch lost sync.
  always_ff @(posedge clk) begin
    if (!rst && imem_resp) begin
      a_resp_has_request: assert (r_inflight != '0);
    end
  end

  fetch_fifo #(
    .WIDTH ($bits(fetch_buf_entry_t)),
    .DEPTH (BUF_DEPTH)
  ) u_resp_buf (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_buf_push),
    .i_wdata (w_buf_wdata),
    .i_pop   (enq),
    .i_flush (w_redirect),
    .o_rdata (w_buf_head),
    .o_empty (w_buf_empty),
    .o_count (w_buf_count)
  );

endmodule

// File: tb/tb_fetch_multi_outstanding.sv
// Directed bench for fetch_multi_outstanding: a table of per-cycle input and
// expected-output records, followed by hand-written multi-cycle sequences.
module tb_fetch_multi_outstanding;
  import rv32i_types::*;

  localparam logic [31:0] A0 = 32'h6000_0000;
  localparam logic [31:0] BR = 32'h6000_0100;

  logic             clk = 1'b0;
  logic             rst, full, branch, imem_ready, imem_resp;
  logic [31:0]      br_pc, imem_rdata;
  logic             imem_req, enq;
  logic [31:0]      imem_addr;
  logic [3:0]       imem_rmask;
  if_id_stage_reg_t if_id_reg_next;
`ifdef FETCH_PREDICT_EN
  logic             prediction, pred_q;
  logic [31:0]      predict_pc, ppc_q;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        rst, full, br;
    logic [31:0] br_pc;
    logic        rdy, resp;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_enq, e_hv;
    logic [31:0] e_pc, e_inst;
  } vec_t;

  vec_t vecs[$];

  fetch_multi_outstanding dut (
    .clk            (clk),
    .rst            (rst),
    .full           (full),
    .branch         (branch),
    .br_pc          (br_pc),
`ifdef FETCH_PREDICT_EN
    .prediction     (prediction),
    .predict_pc     (predict_pc),
`endif
    .imem_ready     (imem_ready),
    .imem_resp      (imem_resp),
    .imem_rdata     (imem_rdata),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rmask     (imem_rmask),
    .enq            (enq),
    .if_id_reg_next (if_id_reg_next)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic rst_i, full_i, br_i, input logic [31:0] brpc,
                              input logic rdy, resp, input logic [31:0] rdata,
                              input logic ereq, input logic [31:0] eaddr,
                              input logic eenq, ehv, input logic [31:0] epc, einst);
    vec_t v;
    v.rst = rst_i; v.full = full_i; v.br = br_i; v.br_pc = brpc;
    v.rdy = rdy; v.resp = resp; v.rdata = rdata;
    v.e_req = ereq; v.e_addr = eaddr; v.e_enq = eenq; v.e_hv = ehv;
    v.e_pc = epc; v.e_inst = einst;
    return v;
  endfunction

  function automatic if_id_stage_reg_t exp_next(input logic hv, input logic [31:0] pc,
                                                input logic [31:0] inst);
    if_id_stage_reg_t r;
    r = '0;
    if (hv) begin
      r.pc = pc; r.pc_next = pc + 32'd4; r.out_inst = inst;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs just after the edge, check outputs mid-cycle.
  task automatic run_row(input string tag, input vec_t v);
    @(posedge clk); #1;
    rst = v.rst; full = v.full; branch = v.br; br_pc = v.br_pc;
    imem_ready = v.rdy; imem_resp = v.resp; imem_rdata = v.rdata;
`ifdef FETCH_PREDICT_EN
    prediction = pred_q; predict_pc = ppc_q;
`endif
    @(negedge clk);
    check({tag, " req"}, 96'(imem_req), 96'(v.e_req));
    if (v.e_req) check({tag, " addr"}, 96'(imem_addr), 96'(v.e_addr));
    check({tag, " enq"}, 96'(enq), 96'(v.e_enq));
    check({tag, " next"}, if_id_reg_next, exp_next(v.e_hv, v.e_pc, v.e_inst));
    check({tag, " rmask"}, 96'(imem_rmask), 96'(4'hF));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; full = 1'b0; branch = 1'b0; br_pc = '0;
    imem_ready = 1'b0; imem_resp = 1'b0; imem_rdata = '0;
`ifdef FETCH_PREDICT_EN
    pred_q = 1'b0; ppc_q = '0; prediction = 1'b0; predict_pc = '0;
`endif

    // rst full br br_pc rdy resp rdata | req addr enq hv pc inst
    vecs.push_back(mk(1,0,0,0, 0,0,0, 0,0, 0,0,0,0));
    vecs.push_back(mk(1,0,0,0, 0,0,0, 0,0, 0,0,0,0));
    // 1-cycle memory streaming
    vecs.push_back(mk(0,0,0,0, 1,0,0,            1,A0,      0,0,0,0));
    vecs.push_back(mk(0,0,0,0, 1,1,32'h1000_0000, 1,A0+32'h4, 0,0,0,0));
    vecs.push_back(mk(0,0,0,0, 1,1,32'h1000_0001, 1,A0+32'h8, 1,1,A0,32'h1000_0000));
    vecs.push_back(mk(0,0,0,0, 1,1,32'h1000_0002, 1,A0+32'hC, 1,1,A0+32'h4,32'h1000_0001));
    // queue full: credits run out at inflight+count = 4, head held
    vecs.push_back(mk(0,1,0,0, 1,1,32'h1000_0003, 1,A0+32'h10, 0,1,A0+32'h8,32'h1000_0002));
    vecs.push_back(mk(0,1,0,0, 1,1,32'h1000_0004, 1,A0+32'h14, 0,1,A0+32'h8,32'h1000_0002));
    vecs.push_back(mk(0,1,0,0, 1,1,32'h1000_0005, 0,0,         0,1,A0+32'h8,32'h1000_0002));
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(0,1,0,0, 1,0,0,           0,0,         0,1,A0+32'h8,32'h1000_0002));
    // release: four consecutive enqueues, issuing resumes as credits free
    vecs.push_back(mk(0,0,0,0, 1,0,0,             0,0,         1,1,A0+32'h8,32'h1000_0002));
    vecs.push_back(mk(0,0,0,0, 1,0,0,             1,A0+32'h18, 1,1,A0+32'hC,32'h1000_0003));
    vecs.push_back(mk(0,0,0,0, 1,1,32'h1000_0006, 1,A0+32'h1C, 1,1,A0+32'h10,32'h1000_0004));
    vecs.push_back(mk(0,0,0,0, 1,1,32'h1000_0007, 1,A0+32'h20, 1,1,A0+32'h14,32'h1000_0005));
    // branch together with a response and a valid head: nothing enqueues
    vecs.push_back(mk(0,0,1,BR, 1,1,32'h1000_0008, 0,0,        0,1,A0+32'h18,32'h1000_0006));
    vecs.push_back(mk(0,0,0,0, 1,0,0,             1,BR,        0,0,0,0));
    vecs.push_back(mk(0,0,0,0, 1,1,32'h2000_0000, 1,BR+32'h4,  0,0,0,0));
    vecs.push_back(mk(0,0,0,0, 1,1,32'h2000_0001, 1,BR+32'h8,  1,1,BR,32'h2000_0000));
    vecs.push_back(mk(0,0,0,0, 0,1,32'h2000_0002, 1,BR+32'hC,  1,1,BR+32'h4,32'h2000_0001));
    vecs.push_back(mk(0,0,0,0, 0,0,0,             1,BR+32'hC,  1,1,BR+32'h8,32'h2000_0002));
    // PC wrap at the top of the address space
    vecs.push_back(mk(0,0,1,32'hFFFF_FFFC, 0,0,0, 0,0,         0,0,0,0));
    vecs.push_back(mk(0,0,0,0, 1,0,0,             1,32'hFFFF_FFFC, 0,0,0,0));
    vecs.push_back(mk(0,0,0,0, 1,1,32'h3000_0000, 1,32'h0,     0,0,0,0));
    vecs.push_back(mk(0,0,0,0, 0,0,0,             1,32'h4,     1,1,32'hFFFF_FFFC,32'h3000_0000));
    vecs.push_back(mk(0,0,0,0, 0,1,32'h3000_0001, 1,32'h4,     0,0,0,0));
    vecs.push_back(mk(0,0,0,0, 0,0,0,             1,32'h4,     1,1,32'h0,32'h3000_0001));
    // reset mid-operation returns to RESET_PC
    vecs.push_back(mk(1,0,0,0, 0,0,0,             0,0,         0,0,0,0));
    vecs.push_back(mk(0,0,0,0, 0,0,0,             1,A0,        0,0,0,0));

    for (int i = 0; i < vecs.size(); i++) run_row($sformatf("vec%0d", i), vecs[i]);

    // 3-cycle memory, branch with two requests in flight: both stale
    // responses are dropped and the first enqueue is the branch target.
    run_row("lat rst", mk(1,0,0,0,  0,0,0,            0,0,        0,0,0,0));
    run_row("lat s0",  mk(0,0,0,0,  1,0,0,            1,A0,       0,0,0,0));
    run_row("lat s1",  mk(0,0,0,0,  1,0,0,            1,A0+32'h4, 0,0,0,0));
    run_row("lat s2",  mk(0,0,1,BR, 1,0,0,            0,0,        0,0,0,0));
    run_row("lat s3",  mk(0,0,0,0,  1,1,32'hDEAD_0000, 0,0,       0,0,0,0));
    run_row("lat s4",  mk(0,0,0,0,  1,1,32'hDEAD_0001, 1,BR,      0,0,0,0));
    run_row("lat s5",  mk(0,0,0,0,  1,0,0,            1,BR+32'h4, 0,0,0,0));
    run_row("lat s6",  mk(0,0,0,0,  1,0,0,            0,0,        0,0,0,0));
    run_row("lat s7",  mk(0,0,0,0,  1,1,32'h4000_0000, 0,0,       0,0,0,0));
    run_row("lat s8",  mk(0,0,0,0,  1,1,32'h4000_0001, 1,BR+32'h8, 1,1,BR,32'h4000_0000));
    run_row("lat s9",  mk(0,0,0,0,  0,0,0,            1,BR+32'hC, 1,1,BR+32'h4,32'h4000_0001));

`ifdef FETCH_PREDICT_EN
    // Predicted-taken on head 0x6000_0008: it still enqueues, fetch moves
    // to 0x6000_0040; then branch and prediction together: branch wins.
    run_row("prd rst", mk(1,0,0,0, 0,0,0,             0,0,         0,0,0,0));
    run_row("prd p0",  mk(0,0,0,0, 1,0,0,             1,A0,        0,0,0,0));
    run_row("prd p1",  mk(0,0,0,0, 1,1,32'h5000_0000, 1,A0+32'h4,  0,0,0,0));
    run_row("prd p2",  mk(0,0,0,0, 1,1,32'h5000_0001, 1,A0+32'h8,  1,1,A0,32'h5000_0000));
    run_row("prd p3",  mk(0,0,0,0, 1,1,32'h5000_0002, 1,A0+32'hC,  1,1,A0+32'h4,32'h5000_0001));
    pred_q = 1'b1; ppc_q = 32'h6000_0040;
    run_row("prd p4",  mk(0,0,0,0, 1,1,32'h5000_0003, 1,A0+32'h10, 1,1,A0+32'h8,32'h5000_0002));
    pred_q = 1'b0;
    run_row("prd p5",  mk(0,0,0,0, 1,1,32'hDEAD_0002, 1,32'h6000_0040, 0,0,0,0));
    run_row("prd p6",  mk(0,0,0,0, 1,1,32'h5000_0040, 1,32'h6000_0044, 0,0,0,0));
    run_row("prd p7",  mk(0,0,0,0, 1,1,32'h5000_0044, 1,32'h6000_0048, 1,1,32'h6000_0040,32'h5000_0040));
    pred_q = 1'b1; ppc_q = 32'h6000_0080;
    run_row("prd p8",  mk(0,0,1,32'h6000_0200, 1,1,32'h5000_0048, 0,0, 0,1,32'h6000_0044,32'h5000_0044));
    pred_q = 1'b0;
    run_row("prd p9",  mk(0,0,0,0, 0,0,0,             1,32'h6000_0200, 0,0,0,0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
